// File: rtl/lane_deskew_calibrator.sv
// ---------------------------------------------------------------------------
// lane_deskew_calibrator
//
// Purpose:
//    Runs IDELAY tap training for the Camera Link LVDS receive lanes in the
//    85 MHz parallel clock domain. Each lane is calibrated in turn. The IDELAY
//    tap is stepped from 0 to the top of its range, and at every tap the
//    deserialized byte is checked against a fixed training pattern. The block
//    keeps the widest run of passing taps and loads its centre into the
//    lane's IDELAY. A lane whose best window is too narrow is flagged as
//    failed and gets the default tap. This block takes the place of the old
//    fixed mid-range taps.
//
// Ports:
//    i_clk          85 MHz parallel clock
//    i_rst          asynchronous active-high reset
//    i_start        single-cycle calibration request (ignored while busy)
//    i_idelay_rdy   IDELAYCTRL ready; dropping it mid-sweep restarts the lane
//    i_lane_data    deserialized bytes, lane n at [n*8 +: 8]
//    o_tap_flat     current tap per lane, lane n at [n*TAP_W +: TAP_W]
//    o_tap_load     one-cycle tap load strobe per lane
//    o_busy         calibration in progress
//    o_done         calibration complete (level)
//    o_fail         at least one lane failed (level)
//    o_fail_mask    per-lane failure flags
//    o_window_flat  (CAL_WINDOW_REPORT_EN only) best window width in taps per
//                   lane, saturated to TAP_MAX, lane n at [n*TAP_W +: TAP_W]
//
// Optional feature macro: CAL_WINDOW_REPORT_EN
// ---------------------------------------------------------------------------
module lane_deskew_calibrator #(
   parameter int         NUM_LANES     = 11,
   parameter int         TAP_W         = 9,
   parameter int         TAP_MAX       = 511,
   parameter int         TAP_STEP      = 4,
   parameter int         SETTLE_CYC    = 16,
   parameter int         SAMPLE_CNT    = 64,
   parameter logic [7:0] TRAIN_PATTERN = 8'hE4,
   parameter int         MIN_WINDOW    = 32,
   parameter int         DEFAULT_TAP   = 256
) (
   input  logic                         i_clk,
   input  logic                         i_rst,
   input  logic                         i_start,
   input  logic                         i_idelay_rdy,
   input  logic [NUM_LANES*8-1:0]       i_lane_data,
   output logic [NUM_LANES*TAP_W-1:0]   o_tap_flat,
   output logic [NUM_LANES-1:0]         o_tap_load,
   output logic                         o_busy,
   output logic                         o_done,
   output logic                         o_fail,
   output logic [NUM_LANES-1:0]         o_fail_mask
`ifdef CAL_WINDOW_REPORT_EN
   ,
   output logic [NUM_LANES*TAP_W-1:0]   o_window_flat
`endif
);

   localparam int LANE_W    = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
   localparam int NUM_STEPS = TAP_MAX / TAP_STEP + 1;
   localparam int RUN_W     = $clog2(NUM_STEPS + 1);
   localparam int CYC_MAX   = (SETTLE_CYC > SAMPLE_CNT) ? SETTLE_CYC : SAMPLE_CNT;
   localparam int CYC_W     = (CYC_MAX > 1) ? $clog2(CYC_MAX) : 1;

   localparam logic [TAP_W:0]      STEP_X      = TAP_STEP[TAP_W:0];
   localparam logic [TAP_W:0]      MAX_X       = TAP_MAX[TAP_W:0];
   localparam logic [TAP_W-1:0]    DEF_TAP     = DEFAULT_TAP[TAP_W-1:0];
   localparam logic [TAP_W-1:0]    MAX_TAP     = TAP_MAX[TAP_W-1:0];
   localparam logic [31:0]         STEP_32     = TAP_STEP;
   localparam logic [31:0]         MAX_32      = TAP_MAX;
   localparam logic [31:0]         MINW_32     = MIN_WINDOW;
   localparam logic [CYC_W-1:0]    SETTLE_LAST = CYC_W'(SETTLE_CYC - 1);
   localparam logic [CYC_W-1:0]    SAMPLE_LAST = CYC_W'(SAMPLE_CNT - 1);
   localparam logic [LANE_W-1:0]   LAST_LANE   = LANE_W'(NUM_LANES - 1);

   typedef enum logic [3:0] {
      IDLE,
      WAIT_RDY,
      SET_TAP,
      LOAD,
      SETTLE,
      SAMPLE,
      EVAL,
      CENTER,
      NEXT_LANE,
      DONE
   } state_t;

   state_t                 state;
   state_t                 state_nxt;

   logic [LANE_W-1:0]      lane;
   logic [TAP_W-1:0]       tap;
   logic [CYC_W-1:0]       cyc_cnt;
   logic                   sample_pass;
   logic [TAP_W-1:0]       run_start;
   logic [RUN_W-1:0]       run_cnt;
   logic [TAP_W-1:0]       best_start;
   logic [RUN_W-1:0]       best_cnt;
   logic [TAP_W-1:0]       tap_reg [NUM_LANES];

   logic [7:0]             lane_byte;
   logic                   byte_ok;
   logic                   abort;
   logic [TAP_W:0]         tap_sum;
   logic                   sweep_end;
   logic [TAP_W-1:0]       run_start_upd;
   logic [RUN_W-1:0]       run_cnt_upd;
   logic                   close_run;
   logic                   take_best;
   logic [31:0]            win_taps;
   logic                   win_ok;
   logic [31:0]            center_32;
   logic [TAP_W-1:0]       center_tap;

`ifdef CAL_WINDOW_REPORT_EN
   logic [TAP_W-1:0]       win_reg [NUM_LANES];
   logic [TAP_W-1:0]       win_sat;
`endif

   // Pick out the byte of the lane under calibration and compare it with the
   // training pattern.
   always_comb begin
      lane_byte = '0;
      for (int n = 0; n < NUM_LANES; n++) begin
         if (lane == LANE_W'(n)) begin
            lane_byte = i_lane_data[n*8 +: 8];
         end
      end
      byte_ok = (lane_byte == TRAIN_PATTERN);
   end

   // Sweep and window bookkeeping for EVAL. A passing tap either opens a new
   // run or extends the open one. The run is closed on a failing tap or at
   // the end of the sweep. When closed it replaces the best window only if it
   // is strictly longer, so on a tie the earlier window is kept.
   always_comb begin
      tap_sum       = {1'b0, tap} + STEP_X;
      sweep_end     = (tap_sum > MAX_X);
      run_start_upd = run_start;
      run_cnt_upd   = run_cnt;
      if (sample_pass) begin
         if (run_cnt == '0) begin
            run_start_upd = tap;
         end
         run_cnt_upd = run_cnt + 1'b1;
      end
      close_run = !sample_pass || sweep_end;
      take_best = close_run && (run_cnt_upd > best_cnt);
   end

   // Centre of the best window. The window always lies inside the sweep, so
   // the centre cannot pass TAP_MAX. The clamp only keeps the arithmetic
   // honest at full width.
   always_comb begin
      win_taps  = 32'(best_cnt) * STEP_32;
      win_ok    = (win_taps >= MINW_32);
      center_32 = 32'(best_start) + 32'(best_cnt >> 1) * STEP_32;
      if (!win_ok) begin
         center_tap = DEF_TAP;
      end else if (center_32 > MAX_32) begin
         center_tap = MAX_TAP;
      end else begin
         center_tap = center_32[TAP_W-1:0];
      end
`ifdef CAL_WINDOW_REPORT_EN
      win_sat = (win_taps > MAX_32) ? MAX_TAP : win_taps[TAP_W-1:0];
`endif
   end

   // Losing IDELAYCTRL ready mid-sweep throws away the current lane's
   // progress. Lanes that are already finished keep their taps.
   assign abort = !i_idelay_rdy &&
                  (state inside {SET_TAP, LOAD, SETTLE, SAMPLE, EVAL});

   // State register.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic and control outputs. The load strobe fires in LOAD for
   // sweep taps and in NEXT_LANE for the centre tap. In both cases the tap
   // was written one cycle earlier, so it is stable while the strobe is high.
   always_comb begin
      state_nxt  = state;
      o_busy     = !((state == IDLE) || (state == DONE));
      o_tap_load = '0;

      for (int n = 0; n < NUM_LANES; n++) begin
         if ((lane == LANE_W'(n)) && ((state == LOAD) || (state == NEXT_LANE))) begin
            o_tap_load[n] = 1'b1;
         end
      end

      case (state)
         IDLE, DONE: begin
            if (i_start) state_nxt = WAIT_RDY;
         end
         WAIT_RDY: begin
            if (i_idelay_rdy) state_nxt = SET_TAP;
         end
         SET_TAP: begin
            state_nxt = LOAD;
         end
         LOAD: begin
            state_nxt = SETTLE;
         end
         SETTLE: begin
            if (cyc_cnt == SETTLE_LAST) state_nxt = SAMPLE;
         end
         SAMPLE: begin
            if (!byte_ok || (cyc_cnt == SAMPLE_LAST)) state_nxt = EVAL;
         end
         EVAL: begin
            state_nxt = sweep_end ? CENTER : SET_TAP;
         end
         CENTER: begin
            state_nxt = NEXT_LANE;
         end
         NEXT_LANE: begin
            state_nxt = (lane == LAST_LANE) ? DONE : WAIT_RDY;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase

      if (abort) state_nxt = WAIT_RDY;
   end

   // Datapath: lane/tap counters, cycle counter, run and best trackers,
   // per-lane tap registers and the result flags.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         lane        <= '0;
         tap         <= '0;
         cyc_cnt     <= '0;
         sample_pass <= 1'b0;
         run_start   <= '0;
         run_cnt     <= '0;
         best_start  <= '0;
         best_cnt    <= '0;
         o_fail_mask <= '0;
         o_done      <= 1'b0;
         o_fail      <= 1'b0;
         for (int n = 0; n < NUM_LANES; n++) begin
            tap_reg[n] <= DEF_TAP;
`ifdef CAL_WINDOW_REPORT_EN
            win_reg[n] <= '0;
`endif
         end
      end else begin
         case (state)
            IDLE, DONE: begin
               if (i_start) begin
                  o_done      <= 1'b0;
                  o_fail      <= 1'b0;
                  o_fail_mask <= '0;
                  lane        <= '0;
`ifdef CAL_WINDOW_REPORT_EN
                  for (int n = 0; n < NUM_LANES; n++) begin
                     win_reg[n] <= '0;
                  end
`endif
               end
            end
            WAIT_RDY: begin
               if (i_idelay_rdy) begin
                  tap        <= '0;
                  run_start  <= '0;
                  run_cnt    <= '0;
                  best_start <= '0;
                  best_cnt   <= '0;
               end
            end
            SET_TAP: begin
               tap_reg[lane] <= tap;
            end
            LOAD: begin
               cyc_cnt <= '0;
            end
            SETTLE: begin
               cyc_cnt <= (cyc_cnt == SETTLE_LAST) ? '0 : cyc_cnt + 1'b1;
            end
            SAMPLE: begin
               if (!byte_ok) begin
                  sample_pass <= 1'b0;
               end else if (cyc_cnt == SAMPLE_LAST) begin
                  sample_pass <= 1'b1;
               end else begin
                  cyc_cnt <= cyc_cnt + 1'b1;
               end
            end
            EVAL: begin
               if (!abort) begin
                  if (close_run) begin
                     run_cnt <= '0;
                     if (take_best) begin
                        best_start <= run_start_upd;
                        best_cnt   <= run_cnt_upd;
                     end
                  end else begin
                     run_start <= run_start_upd;
                     run_cnt   <= run_cnt_upd;
                  end
                  if (!sweep_end) begin
                     tap <= tap_sum[TAP_W-1:0];
                  end
               end
            end
            CENTER: begin
               tap           <= center_tap;
               tap_reg[lane] <= center_tap;
               if (!win_ok) begin
                  o_fail_mask[lane] <= 1'b1;
               end
`ifdef CAL_WINDOW_REPORT_EN
               win_reg[lane] <= win_sat;
`endif
            end
            NEXT_LANE: begin
               if (lane == LAST_LANE) begin
                  o_done <= 1'b1;
                  o_fail <= |o_fail_mask;
               end else begin
                  lane <= lane + 1'b1;
               end
            end
            default: begin
            end
         endcase
      end
   end

   // Flatten the per-lane registers onto the output buses.
   for (genvar g = 0; g < NUM_LANES; g++) begin : g_flat
      assign o_tap_flat[g*TAP_W +: TAP_W] = tap_reg[g];
`ifdef CAL_WINDOW_REPORT_EN
      assign o_window_flat[g*TAP_W +: TAP_W] = win_reg[g];
`endif
   end

endmodule

// File: tb/tb_lane_deskew_calibrator.sv
// ---------------------------------------------------------------------------
// tb_lane_deskew_calibrator
//
// Directed bench for lane_deskew_calibrator. A small channel model drives each
// lane's byte from that lane's current tap: the byte is the training pattern
// inside the scenario's good-tap window and a one-bit-off byte outside it.
// Settle and sample counts are shortened to keep full sweeps quick. The tap
// range, step and window threshold stay at their normal values, so the
// hand-computed centre taps still apply.
// ---------------------------------------------------------------------------
module tb_lane_deskew_calibrator;

   localparam int NL = 11;
   localparam int TW = 9;

   logic             clk_fpga_510;
   logic             rst;
   logic             start;
   logic             idelay_rdy;
   logic [NL*8-1:0]  lane_data;
   logic [NL*TW-1:0] tap_flat;
   logic [NL-1:0]    tap_load;
   logic             busy;
   logic             done;
   logic             fail;
   logic [NL-1:0]    fail_mask;
`ifdef CAL_WINDOW_REPORT_EN
   logic [NL*TW-1:0] window_flat;
`endif

   int vector_count;
   int miscompare_count;
   int scenario;
   int load_total [NL];
   int base [NL];
   int gap;
   int seen;
   int restart_tap;

   lane_deskew_calibrator #(
      .NUM_LANES  (NL),
      .TAP_W      (TW),
      .SETTLE_CYC (2),
      .SAMPLE_CNT (3)
   ) dut (
      .i_clk         (clk_fpga_510),
      .i_rst         (rst),
      .i_start       (start),
      .i_idelay_rdy  (idelay_rdy),
      .i_lane_data   (lane_data),
      .o_tap_flat    (tap_flat),
      .o_tap_load    (tap_load),
      .o_busy        (busy),
      .o_done        (done),
      .o_fail        (fail),
      .o_fail_mask   (fail_mask)
`ifdef CAL_WINDOW_REPORT_EN
      ,
      .o_window_flat (window_flat)
`endif
   );

   // 85 MHz-ish free-running clock (period only matters relatively).
   initial clk_fpga_510 = 1'b0;
   always #5 clk_fpga_510 = ~clk_fpga_510;

   // Good-tap windows per scenario: 0 = every lane clean everywhere,
   // 1 = lane 0 two windows, lane 3 narrow window, lane 5 dead.
   function automatic bit lane_ok(input int mode, input int n, input int t);
      if (mode == 0) return 1'b1;
      case (n)
         0:       return (t <= 40) || ((t >= 300) && (t <= 400));
         3:       return (t >= 100) && (t <= 200);
         5:       return 1'b0;
         default: return 1'b1;
      endcase
   endfunction

   // Final tap each lane should end up with, worked out by hand.
   function automatic int exp_tap(input int mode, input int n);
      if (mode == 1 && n == 0) return 352;
      if (mode == 1 && n == 3) return 152;
      return 256;
   endfunction

   // Channel model: each lane's byte follows its own current tap.
   always_comb begin
      for (int n = 0; n < NL; n++) begin
         lane_data[n*8 +: 8] = lane_ok(scenario, n, int'(tap_flat[n*TW +: TW])) ? 8'hE4 : 8'hE5;
      end
   end

   // Count load strobes per lane, sampled mid-cycle.
   always @(negedge clk_fpga_510) begin
      for (int n = 0; n < NL; n++) begin
         if (tap_load[n]) load_total[n] <= load_total[n] + 1;
      end
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      vector_count++;
      if (observed !== expected) begin
         miscompare_count++;
         $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input int mode);
      @(negedge clk_fpga_510);
      scenario = mode;
      start    = 1'b1;
      @(negedge clk_fpga_510);
      start    = 1'b0;
   endtask

   task automatic snapLoads();
      for (int n = 0; n < NL; n++) base[n] = load_total[n];
   endtask

   task automatic waitDone(input string tag, input int budget);
      for (int i = 0; i < budget; i++) begin
         @(negedge clk_fpga_510);
         if (done) break;
      end
      checkOutput(tag, 32'(done), 32'd1);
   endtask

   // Cycles between the first two load strobes seen on a lane.
   task automatic measureGap(input int lane_idx, output int g);
      g = -1;
      for (int i = 0; i < 20000; i++) begin
         @(negedge clk_fpga_510);
         if (tap_load[lane_idx]) break;
      end
      for (int i = 1; i < 100; i++) begin
         @(negedge clk_fpga_510);
         if (tap_load[lane_idx]) begin
            g = i;
            break;
         end
      end
   endtask

   task automatic waitLanePulses(input int lane_idx, input int pulses);
      seen = 0;
      for (int i = 0; i < 20000; i++) begin
         @(negedge clk_fpga_510);
         if (tap_load[lane_idx]) seen++;
         if (seen >= pulses) break;
      end
      checkOutput($sformatf("pulses_lane%0d", lane_idx), 32'(seen), 32'(pulses));
   endtask

   task automatic checkTaps(input string tag, input int mode);
      for (int n = 0; n < NL; n++) begin
         checkOutput($sformatf("%s_tap%0d", tag, n), 32'(tap_flat[n*TW +: TW]), 32'(exp_tap(mode, n)));
      end
   endtask

   initial begin
      vector_count     = 0;
      miscompare_count = 0;
      scenario         = 0;
      rst              = 1'b1;
      start            = 1'b0;
      idelay_rdy       = 1'b1;
      repeat (3) @(negedge clk_fpga_510);

      // Reset values.
      checkTaps("rst", 0);
      checkOutput("rst_load", 32'(tap_load), 32'd0);
      checkOutput("rst_busy", 32'(busy), 32'd0);
      checkOutput("rst_done", 32'(done), 32'd0);
      checkOutput("rst_fail", 32'(fail), 32'd0);
      checkOutput("rst_mask", 32'(fail_mask), 32'd0);
      rst = 1'b0;
      @(negedge clk_fpga_510);

      // Run A: all lanes clean; held in WAIT_RDY first; stray start mid-run.
      $display("[TB] run A: all lanes pass");
      idelay_rdy = 1'b0;
      snapLoads();
      applyStimulus(0);
      repeat (5) @(negedge clk_fpga_510);
      checkOutput("wait_rdy_busy", 32'(busy), 32'd1);
      checkOutput("wait_rdy_noload", 32'(load_total[0] - base[0]), 32'd0);
      idelay_rdy = 1'b1;
      measureGap(0, gap);
      checkOutput("pass_tap_gap", 32'(gap), 32'd8);
      applyStimulus(0);
      checkOutput("midrun_busy", 32'(busy), 32'd1);
      checkOutput("midrun_done", 32'(done), 32'd0);
      waitDone("runA_done", 15000);
      checkTaps("runA", 0);
      checkOutput("runA_fail", 32'(fail), 32'd0);
      checkOutput("runA_mask", 32'(fail_mask), 32'd0);
      checkOutput("runA_busy", 32'(busy), 32'd0);
      checkOutput("runA_loads0", 32'(load_total[0] - base[0]), 32'd129);
      checkOutput("runA_loads10", 32'(load_total[10] - base[10]), 32'd129);

      // Run B: lane 0 two windows, lane 3 narrow window, lane 5 dead.
      $display("[TB] run B: mixed windows");
      snapLoads();
      applyStimulus(1);
      measureGap(5, gap);
      checkOutput("fail_tap_gap", 32'(gap), 32'd6);
      waitDone("runB_done", 15000);
      checkTaps("runB", 1);
      checkOutput("runB_mask", 32'(fail_mask), 32'h020);
      checkOutput("runB_fail", 32'(fail), 32'd1);
      for (int n = 0; n < NL; n++) begin
         checkOutput($sformatf("runB_loads%0d", n), 32'(load_total[n] - base[n]), 32'd129);
      end

      // Run C: IDELAYCTRL ready drops for 20 cycles during lane 2.
      $display("[TB] run C: ready drop on lane 2");
      snapLoads();
      applyStimulus(1);
      waitLanePulses(2, 10);
      idelay_rdy = 1'b0;
      repeat (20) @(negedge clk_fpga_510);
      checkOutput("abort_busy", 32'(busy), 32'd1);
      idelay_rdy = 1'b1;
      restart_tap = -1;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk_fpga_510);
         if (tap_load[2]) begin
            restart_tap = int'(tap_flat[2*TW +: TW]);
            break;
         end
      end
      checkOutput("abort_restart_tap", 32'(restart_tap), 32'd0);
      waitDone("runC_done", 15000);
      checkTaps("runC", 1);
      checkOutput("runC_mask", 32'(fail_mask), 32'h020);
      checkOutput("runC_loads0", 32'(load_total[0] - base[0]), 32'd129);
      checkOutput("runC_loads1", 32'(load_total[1] - base[1]), 32'd129);

      // Run D: reset mid-sweep on lane 7, then a fresh clean calibration.
      $display("[TB] run D: reset during lane 7");
      applyStimulus(1);
      waitLanePulses(7, 5);
      rst = 1'b1;
      #2;
      checkTaps("midrst", 0);
      checkOutput("midrst_load", 32'(tap_load), 32'd0);
      checkOutput("midrst_busy", 32'(busy), 32'd0);
      checkOutput("midrst_done", 32'(done), 32'd0);
      checkOutput("midrst_mask", 32'(fail_mask), 32'd0);
      @(negedge clk_fpga_510);
      rst = 1'b0;
      repeat (2) @(negedge clk_fpga_510);
      snapLoads();
      applyStimulus(0);
      waitDone("runD_done", 15000);
      checkTaps("runD", 0);
      checkOutput("runD_mask", 32'(fail_mask), 32'd0);
      checkOutput("runD_fail", 32'(fail), 32'd0);
      checkOutput("runD_loads0", 32'(load_total[0] - base[0]), 32'd129);

      $display("== %0d vectors applied, %0d miscompares ==", vector_count, miscompare_count);
      $finish;
   end

endmodule
